// File: rtl/traffic_pkg.sv
// Shared traffic-controller definitions: phase codes (common with the NS/EW
// controller encoding) and the phase timer FSM states.
package traffic_pkg;

   localparam logic [1:0] PH_RED    = 2'b00;
   localparam logic [1:0] PH_GREEN  = 2'b01;
   localparam logic [1:0] PH_YELLOW = 2'b10;
   localparam logic [1:0] PH_RSVD   = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic logic [7:0] phase_dur(input logic [1:0] ph,
                                            input logic [7:0] red_s,
                                            input logic [7:0] green_s,
                                            input logic [7:0] yellow_s);
      logic [7:0] d;
      d = red_s;
      case (ph)
         PH_GREEN:  d = green_s;
         PH_YELLOW: d = yellow_s;
         default:   d = red_s;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..CLK_HZ-1 divider with sync restart and enable; emits a
// registered one-cycle tick plus a same-cycle terminal strobe for the FSM.
module tick_prescaler #(
   parameter int CLK_HZ = 2080000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic en,
   output logic tick,
   output logic term
);

   localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [W-1:0] MAX = W'(CLK_HZ - 1);

   logic [W-1:0] cnt;

   // term lets the countdown step on the same edge the registered tick rises
   assign term = en && (cnt == MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= term && !restart;
         if (restart)
            cnt <= '0;
         else if (en)
            cnt <= (cnt == MAX) ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase-duration timer: loads GREEN/YELLOW/RED duration on request, counts
// whole seconds off the prescaler and pulses expire when the phase ends.
module traffic_phase_timer
   import traffic_pkg::*;
#(
   parameter int CLK_HZ   = 2080000,
   parameter int GREEN_S  = 30,
   parameter int YELLOW_S = 5,
   parameter int RED_S    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [1:0] phase,
   input  logic       hold,
   output logic       tick_1s,
   output logic       busy,
   output logic       expire,
   output logic [7:0] remaining
);

   if (GREEN_S < 1 || GREEN_S > 255) begin : g_bad_green
      $error("GREEN_S must be in 1..255");
   end
   if (YELLOW_S < 1 || YELLOW_S > 255) begin : g_bad_yellow
      $error("YELLOW_S must be in 1..255");
   end
   if (RED_S < 1 || RED_S > 255) begin : g_bad_red
      $error("RED_S must be in 1..255");
   end

   state_t     state, state_n;
   logic [7:0] rem_n;
   logic       exp_n;
   logic       ld_ok;
   logic       term;

   assign ld_ok = load && (phase != PH_RSVD);

   tick_prescaler #(.CLK_HZ(CLK_HZ)) u_psc (
      .clk     (clk),
      .reset   (reset),
      .restart (ld_ok),
      .en      (!hold),
      .tick    (tick_1s),
      .term    (term)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         remaining <= 8'd0;
         expire    <= 1'b0;
      end else begin
         state     <= state_n;
         remaining <= rem_n;
         expire    <= exp_n;
      end
   end

   // A load overrides a coinciding terminal count, so an abandoned phase never expires
   always_comb begin
      state_n = state;
      rem_n   = remaining;
      exp_n   = 1'b0;
      if (ld_ok) begin
         state_n = RUN;
         rem_n   = phase_dur(phase, 8'(RED_S), 8'(GREEN_S), 8'(YELLOW_S));
      end else if (state == RUN && term) begin
         if (remaining <= 8'd1) begin
            state_n = IDLE;
            rem_n   = 8'd0;
            exp_n   = 1'b1;
         end else begin
            rem_n = remaining - 8'd1;
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: doc/traffic_phase_timer.md
# traffic_phase_timer

Phase-duration timer sitting directly upstream of the traffic control FSM. It divides the on-chip oscillator clock down to a 1 s tick. On request it counts the duration of the current signal phase (GREEN, YELLOW or all-RED clearance), then returns a single-cycle expire pulse, which the controller uses to advance the NS/EW lights.

## Interface
Parameters:
- CLK_HZ, 2080000: input clock frequency in Hz (internal oscillator, 2.08 MHz); prescaler terminal count is CLK_HZ-1.
- GREEN_S, 30: green phase duration, seconds, legal range 1..255.
- YELLOW_S, 5: yellow phase duration, seconds, legal range 1..255.
- RED_S, 2: all-red clearance duration, seconds, legal range 1..255.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle request to start timing a phase.
- phase  in  2  phase code sampled with load: 00 RED, 01 GREEN, 10 YELLOW, 11 reserved.
- hold  in  1  level; freezes the prescaler and countdown while high.
- tick_1s  out  1  one-cycle pulse, once per CLK_HZ unheld cycles.
- busy  out  1  high while a phase is being timed.
- expire  out  1  one-cycle pulse when the timed phase ends.
- remaining  out  8  whole seconds left in the current phase; 0 when idle.

## Operation
- Reset value of every output is 0, applied asynchronously while reset is low. The prescaler counter and FSM also clear.
- The prescaler counts 0..CLK_HZ-1 free-running, including when idle. tick_1s is registered high on the cycle after the counter hits CLK_HZ-1.
- FSM states:
  - IDLE: busy=0, remaining=0. A valid load moves to RUN.
  - RUN: busy=1. On each tick, remaining decrements. On the tick where remaining==1: remaining goes to 0, expire pulses high for one cycle, busy goes to 0, and the FSM returns to IDLE.
- Accepting a load:
  - remaining takes the duration for the sampled phase (00 gives RED_S, 01 gives GREEN_S, 10 gives YELLOW_S).
  - The prescaler restarts at 0, so the first second is full length.
- phase 11 with load: the request is ignored and state is unchanged, including an in-progress run.
- Load while in RUN restarts timing with the new phase. No expire is produced for the abandoned phase.
- Load and tick in the same cycle: load wins and the tick is not applied to the new count.
- hold high:
  - The prescaler freezes and tick_1s is suppressed.
  - remaining holds and expire cannot fire.
  - load is still accepted; counting starts when hold drops.
- Reset mid-run aborts to IDLE immediately. No expire is generated on release.
- Width rules:
  - Prescaler width is $clog2(CLK_HZ).
  - remaining is 8 bits unsigned and never decrements below 0.
  - Duration parameters outside 1..255 are an elaboration error.

## Timing
- Load at edge L: busy=1 and remaining=duration are visible after edge L (one-cycle latency).
- With no hold, the expire pulse is visible after edge L + duration*CLK_HZ.
- Each cycle with hold high extends that by exactly one cycle.
- tick_1s, expire, busy and remaining are all registered; there are no combinational paths from inputs to outputs.
- expire and busy falling occur on the same edge. The controller may issue the next load on the cycle expire is high.

## Structure
- Shared package traffic_pkg holds:
  - the phase code constants (PH_RED=2'b00, PH_GREEN=2'b01, PH_YELLOW=2'b10), shared with the controller's NS/EW encoding;
  - the FSM state enum (IDLE, RUN).
- Sub-module tick_prescaler contains the CLK_HZ counter with sync restart and enable inputs, and drives the tick pulse.
- The top level contains the FSM, the duration mux and the remaining counter.

## Test plan
All scenarios use CLK_HZ=4, GREEN_S=3, YELLOW_S=2, RED_S=1.
- Reset, then idle 20 cycles -> busy=0, expire=0, remaining=0, tick_1s pulses every 4 cycles.
- load with phase=01 at edge 0 -> remaining=3 after edge 0, decrements at edges 4 and 8, and expire is a single-cycle pulse after edge 12 with busy=0 and remaining=0.
- GREEN loaded at edge 0, then YELLOW loaded at edge 5 -> remaining=2 after edge 5, no expire at edge 12, expire after edge 13.
- RED loaded, then hold high for 10 cycles starting at edge 2 -> no tick_1s during hold, expire after edge 14 instead of 4.
- load with phase=11 while idle and again mid-GREEN -> ignored, state unchanged, GREEN still expires on schedule.
- reset driven low mid-GREEN at a non-edge time -> outputs clear without waiting for clk; after release, no expire and busy=0.
